// File: rtl/fp_led_shift_driver.sv
// Serial driver for the front-panel 74HC595-style LED chain: shifts a held word out MSB-first,
// latches it, re-sends it periodically and PWM-dims the chain's output enable.
module fp_led_shift_driver #(
  parameter int unsigned C_S00_AXI_ACLK_FREQ_HZ = 100000000,
  parameter int unsigned SHIFT_FREQ_HZ          = 25000000,
  parameter int unsigned NUM_LEDS               = 16,
  parameter int unsigned REFRESH_CYCLES         = 1000000
) (
  input  logic                S_AXI_ACLK,
  input  logic                S_AXI_ARESET,
  input  logic [NUM_LEDS-1:0] LED_WDATA,
  input  logic                LED_WVALID,
  output logic                LED_WREADY,
  input  logic [7:0]          BRIGHTNESS,
  output logic                BUSY,
  output logic                LED_CLOCK,
  output logic                LED_DATA,
  output logic                LED_LATCH,
  output logic                LED_OE_N
);

  localparam int unsigned H_RAW = C_S00_AXI_ACLK_FREQ_HZ / (2 * SHIFT_FREQ_HZ);
  localparam int unsigned H     = (H_RAW < 1) ? 1 : H_RAW;
  localparam int unsigned PH_W  = (H > 1) ? $clog2(H) : 1;
  localparam int unsigned BIT_W = $clog2(NUM_LEDS);
  localparam int unsigned REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(H - 1);
  localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(NUM_LEDS - 1);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_CLEAR    = 3'd0,
    ST_IDLE     = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_LATCH    = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [NUM_LEDS-1:0] held_q, held_d;
  logic [REF_W-1:0]    refresh_q, refresh_d;
  logic [7:0]          pwm_q, pwm_d;
  logic                led_clock_q, led_clock_d;
  logic                led_data_q, led_data_d;
  logic                led_latch_q, led_latch_d;
  logic                led_oe_n_q, led_oe_n_d;
  logic                led_wready_q, led_wready_d;
  logic                busy_q, busy_d;
  logic                phase_done_s;

  // Next-state, counters and next output values (outputs are derived from the next state so they stay registered)
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    bit_d        = bit_q;
    held_d       = held_q;
    refresh_d    = refresh_q;
    phase_done_s = (phase_q == PH_LAST);

    case (state_q)
      ST_CLEAR: begin
        held_d    = '0;
        state_d   = ST_SHIFT_LO;
        phase_d   = '0;
        bit_d     = BIT_TOP;
        refresh_d = '0;
      end
      ST_IDLE: begin
        // An accept on the refresh-due cycle wins; both paths start the same single transfer.
        if (LED_WVALID && led_wready_q) begin
          held_d    = LED_WDATA;
          state_d   = ST_SHIFT_LO;
          phase_d   = '0;
          bit_d     = BIT_TOP;
          refresh_d = '0;
        end else if (refresh_q == REF_LAST) begin
          state_d   = ST_SHIFT_LO;
          phase_d   = '0;
          bit_d     = BIT_TOP;
          refresh_d = '0;
        end else begin
          refresh_d = refresh_q + REF_W'(1);
        end
      end
      ST_SHIFT_LO: begin
        if (phase_done_s) begin
          state_d = ST_SHIFT_HI;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      ST_SHIFT_HI: begin
        if (phase_done_s) begin
          phase_d = '0;
          if (bit_q == '0) begin
            state_d = ST_LATCH;
          end else begin
            state_d = ST_SHIFT_LO;
            bit_d   = bit_q - BIT_W'(1);
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      ST_LATCH: begin
        if (phase_done_s) begin
          state_d = ST_IDLE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      default: begin
        state_d = ST_CLEAR;
        phase_d = '0;
        bit_d   = BIT_TOP;
      end
    endcase

    led_clock_d  = (state_d == ST_SHIFT_HI);
    led_latch_d  = (state_d == ST_LATCH);
    led_wready_d = (state_d == ST_IDLE);
    busy_d       = (state_d != ST_IDLE);
    if (state_d == ST_SHIFT_LO) begin
      led_data_d = held_d[bit_d];
    end else begin
      led_data_d = led_data_q;
    end

    if (pwm_q == 8'd254) begin
      pwm_d = 8'd0;
    end else begin
      pwm_d = pwm_q + 8'd1;
    end
    led_oe_n_d = !(pwm_q < BRIGHTNESS);
  end

  // State, counters and output registers with synchronous reset
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state_q      <= ST_CLEAR;
      phase_q      <= '0;
      bit_q        <= BIT_TOP;
      held_q       <= '0;
      refresh_q    <= '0;
      pwm_q        <= 8'd0;
      led_clock_q  <= 1'b0;
      led_data_q   <= 1'b0;
      led_latch_q  <= 1'b0;
      led_oe_n_q   <= 1'b1;
      led_wready_q <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      bit_q        <= bit_d;
      held_q       <= held_d;
      refresh_q    <= refresh_d;
      pwm_q        <= pwm_d;
      led_clock_q  <= led_clock_d;
      led_data_q   <= led_data_d;
      led_latch_q  <= led_latch_d;
      led_oe_n_q   <= led_oe_n_d;
      led_wready_q <= led_wready_d;
      busy_q       <= busy_d;
    end
  end

  assign LED_CLOCK  = led_clock_q;
  assign LED_DATA   = led_data_q;
  assign LED_LATCH  = led_latch_q;
  assign LED_OE_N   = led_oe_n_q;
  assign LED_WREADY = led_wready_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_fp_led_shift_driver.sv
// Directed bench for fp_led_shift_driver with NUM_LEDS=8, H=2, REFRESH_CYCLES=50.
module tb_fp_led_shift_driver;

  localparam int N  = 8;
  localparam int H  = 2;
  localparam int RC = 50;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] wdata;
  logic         wvalid;
  logic         wready;
  logic [7:0]   bright;
  logic         busy;
  logic         led_clock;
  logic         led_data;
  logic         led_latch;
  logic         led_oe_n;

  int checks = 0;
  int errors = 0;

  fp_led_shift_driver #(
    .C_S00_AXI_ACLK_FREQ_HZ(100000000),
    .SHIFT_FREQ_HZ         (25000000),
    .NUM_LEDS              (N),
    .REFRESH_CYCLES        (RC)
  ) dut (
    .S_AXI_ACLK  (clk),
    .S_AXI_ARESET(rst),
    .LED_WDATA   (wdata),
    .LED_WVALID  (wvalid),
    .LED_WREADY  (wready),
    .BRIGHTNESS  (bright),
    .BUSY        (busy),
    .LED_CLOCK   (led_clock),
    .LED_DATA    (led_data),
    .LED_LATCH   (led_latch),
    .LED_OE_N    (led_oe_n)
  );

  always #5 clk = ~clk;

  // Chain model: capture LED_DATA at each LED_CLOCK rise, count latch pulses, check data stability and latch gap
  int unsigned cyc = 0;
  int unsigned rises = 0;
  int unsigned latches = 0;
  int unsigned latch_hi = 0;
  int unsigned glitches = 0;
  int unsigned gap_errs = 0;
  int unsigned last_rise_cyc = 0;
  logic [63:0] cap = 64'd0;
  logic prev_clk = 1'b0;
  logic prev_latch = 1'b0;
  logic prev_data = 1'b0;
  logic rise_bit = 1'b0;

  always @(negedge clk) begin
    if (!prev_clk && led_clock) begin
      rises         <= rises + 1;
      cap           <= {cap[62:0], led_data};
      rise_bit      <= led_data;
      last_rise_cyc <= cyc;
      if (led_data !== prev_data) glitches <= glitches + 1;
    end else if (prev_clk && led_clock && (led_data !== rise_bit)) begin
      glitches <= glitches + 1;
    end
    if (!prev_latch && led_latch) begin
      latches <= latches + 1;
      if (cyc - last_rise_cyc != H) gap_errs <= gap_errs + 1;
    end
    if (led_latch) latch_hi <= latch_hi + 1;
    prev_clk   <= led_clock;
    prev_latch <= led_latch;
    prev_data  <= led_data;
    cyc        <= cyc + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Counts samples with WREADY low, starting at the current sample, until it rises (bounded).
  task automatic wait_ready(output int n);
    n = 0;
    while (!wready && n < 300) begin
      n++;
      tick();
    end
  endtask

  task automatic do_write(input logic [N-1:0] d);
    wdata  = d;
    wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0] wdata;
    logic [N-1:0] exp_stream;
  } wr_vec_t;

  typedef struct {
    logic [7:0] bright;
    int         exp_low;
  } br_vec_t;

  wr_vec_t     wr_tab[5];
  br_vec_t     br_tab[4];
  int          n;
  int unsigned r0, l0, h0;

  initial begin
    wr_tab[0] = '{8'hA5, 8'hA5};
    wr_tab[1] = '{8'h00, 8'h00};
    wr_tab[2] = '{8'hFF, 8'hFF};
    wr_tab[3] = '{8'h80, 8'h80};
    wr_tab[4] = '{8'h01, 8'h01};
    br_tab[0] = '{8'd0,   0};
    br_tab[1] = '{8'd1,   1};
    br_tab[2] = '{8'd128, 128};
    br_tab[3] = '{8'd255, 255};

    rst    = 1'b1;
    wdata  = '0;
    wvalid = 1'b0;
    bright = 8'd128;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("oe_n_in_reset", {63'd0, led_oe_n}, 64'd1);
    end
    check("rst_clock",  {63'd0, led_clock}, 64'd0);
    check("rst_data",   {63'd0, led_data},  64'd0);
    check("rst_latch",  {63'd0, led_latch}, 64'd0);
    check("rst_wready", {63'd0, wready},    64'd0);
    check("rst_busy",   {63'd0, busy},      64'd1);

    // Release: CLEAR transfer of zeros
    r0 = rises; l0 = latches; h0 = latch_hi;
    rst = 1'b0;
    wait_ready(n);
    check("clear_ready_delay", 64'(n), 64'd35);
    check("clear_rises", 64'(rises - r0), 64'd8);
    check("clear_stream", {56'd0, cap[7:0]}, 64'd0);
    check("clear_latches", 64'(latches - l0), 64'd1);
    check("clear_latch_width", 64'(latch_hi - h0), 64'(H));
    check("idle_busy", {63'd0, busy}, 64'd0);

    // Table-driven writes from IDLE
    for (int i = 0; i < 5; i++) begin
      r0 = rises; l0 = latches;
      do_write(wr_tab[i].wdata);
      check("accept_wready_low", {63'd0, wready}, 64'd0);
      check("accept_busy", {63'd0, busy}, 64'd1);
      check("first_bit_msb", {63'd0, led_data}, {63'd0, wr_tab[i].wdata[N-1]});
      wait_ready(n);
      check("wr_ready_low_cycles", 64'(n), 64'd34);
      check("wr_stream", {56'd0, cap[7:0]}, {56'd0, wr_tab[i].exp_stream});
      check("wr_rises", 64'(rises - r0), 64'd8);
      check("wr_latches", 64'(latches - l0), 64'd1);
    end

    // WVALID held with 0x3C during a transfer: not accepted until ready, shifted once
    r0 = rises;
    do_write(8'h11);
    wdata  = 8'h3C;
    wvalid = 1'b1;
    wait_ready(n);
    check("hold_first_stream", {56'd0, cap[7:0]}, 64'h11);
    check("hold_first_rises", 64'(rises - r0), 64'd8);
    r0 = rises; l0 = latches;
    tick();
    wvalid = 1'b0;
    wait_ready(n);
    check("hold_second_stream", {56'd0, cap[7:0]}, 64'h3C);
    repeat (10) tick();
    check("hold_second_once", 64'(rises - r0), 64'd8);
    check("hold_second_latch", 64'(latches - l0), 64'd1);
    wait_ready(n);

    // Refresh after 50 idle cycles, twice (idle time already spent above is counted in the first window)
    n = 0;
    while (wready && n < 300) begin n++; tick(); end
    check("refresh_idle_partial", 64'(n), 64'(RC - 10));
    r0 = rises; l0 = latches;
    wait_ready(n);
    for (int k = 0; k < 2; k++) begin
      r0 = rises; l0 = latches;
      n = 0;
      while (wready && n < 300) begin n++; tick(); end
      check("refresh_idle_cycles", 64'(n), 64'(RC));
      wait_ready(n);
      check("refresh_stream", {56'd0, cap[7:0]}, 64'h3C);
      check("refresh_rises", 64'(rises - r0), 64'd8);
      check("refresh_latches", 64'(latches - l0), 64'd1);
    end

    // Write arriving on the refresh-due cycle: one transfer with the new data
    repeat (RC - 1) tick();
    r0 = rises; l0 = latches;
    do_write(8'h96);
    wait_ready(n);
    check("collide_ready_low", 64'(n), 64'd34);
    check("collide_stream", {56'd0, cap[7:0]}, 64'h96);
    check("collide_rises", 64'(rises - r0), 64'd8);
    check("collide_latches", 64'(latches - l0), 64'd1);
    n = 0;
    while (wready && n < 300) begin n++; tick(); end
    check("collide_next_refresh", 64'(n), 64'(RC));
    wait_ready(n);
    check("collide_refresh_stream", {56'd0, cap[7:0]}, 64'h96);

    // Reset during bit 3 of a transfer
    r0 = rises; l0 = latches;
    do_write(8'hFF);
    n = 0;
    while ((rises - r0) < 5 && n < 300) begin n++; tick(); end
    check("midrst_reached_bit3", 64'(rises - r0), 64'd5);
    rst = 1'b1;
    tick();
    check("midrst_clock",  {63'd0, led_clock}, 64'd0);
    check("midrst_data",   {63'd0, led_data},  64'd0);
    check("midrst_latch",  {63'd0, led_latch}, 64'd0);
    check("midrst_oe_n",   {63'd0, led_oe_n},  64'd1);
    check("midrst_wready", {63'd0, wready},    64'd0);
    check("midrst_busy",   {63'd0, busy},      64'd1);
    repeat (3) tick();
    check("midrst_no_latch", 64'(latches - l0), 64'd0);
    r0 = rises;
    rst = 1'b0;
    wait_ready(n);
    check("midrst_clear_delay", 64'(n), 64'd35);
    check("midrst_clear_rises", 64'(rises - r0), 64'd8);
    check("midrst_clear_stream", {56'd0, cap[7:0]}, 64'd0);
    check("midrst_clear_latch", 64'(latches - l0), 64'd1);

    // Brightness sweep over one 255-cycle window each
    for (int i = 0; i < 4; i++) begin
      bright = br_tab[i].bright;
      repeat (5) tick();
      n = 0;
      for (int c = 0; c < 255; c++) begin
        if (!led_oe_n) n++;
        tick();
      end
      check("pwm_low_cycles", 64'(n), 64'(br_tab[i].exp_low));
    end

    check("data_stability", 64'(glitches), 64'd0);
    check("latch_gap", 64'(gap_errs), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_led_shift_driver.md
# fp_led_shift_driver

Serial driver for the front-panel LED shift-register chain, the output-direction counterpart of the front-panel button matrix scanner. It accepts a parallel LED state word over a valid/ready handshake and shifts it MSB-first into an external 74HC595-style chain, using a clock, a data line and a latch strobe. It also periodically refreshes the chain with the last accepted word and PWM-dims the chain's output enable. It sits beside the button scanner inside the front-panel IP, fed by the AXI register file.

## Interface
- C_S00_AXI_ACLK_FREQ_HZ, 100000000, input clock frequency.
- SHIFT_FREQ_HZ, 25000000, target LED_CLOCK frequency.
  - H = C_S00_AXI_ACLK_FREQ_HZ / (2*SHIFT_FREQ_HZ), truncated; minimum 1. H is the length of one clock phase in cycles.
- NUM_LEDS, 16, chain length in bits (2..64).
- REFRESH_CYCLES, 1000000, number of idle cycles between automatic re-sends (≥ 1).
- S_AXI_ACLK  in  1  sole clock.
- S_AXI_ARESET  in  1  synchronous, active-high reset.
- LED_WDATA  in  NUM_LEDS  new LED state; bit i drives LED i.
- LED_WVALID  in  1  LED_WDATA valid.
- LED_WREADY  out  1  block can accept a word.
- BRIGHTNESS  in  8  PWM duty (0 = off, 255 = fully on); sampled every cycle.
- BUSY  out  1  transfer in progress.
- LED_CLOCK  out  1  shift clock to chain; the chain samples on its rising edge.
- LED_DATA  out  1  serial data.
- LED_LATCH  out  1  storage-register strobe.
- LED_OE_N  out  1  active-low output enable of the chain.

## Operation
- FSM states: CLEAR, IDLE, SHIFT_LO, SHIFT_HI, LATCH.
  - Phase counter counts 0..H-1.
  - Bit counter counts NUM_LEDS-1 down to 0.
- Reset values, held while S_AXI_ARESET=1:
  - LED_CLOCK=0, LED_DATA=0, LED_LATCH=0, LED_OE_N=1, LED_WREADY=0, BUSY=1.
  - Held word = 0; refresh and PWM counters = 0; state = CLEAR.
- CLEAR: on the first cycle after reset release, start a full transfer of all zeros. LED_WREADY stays 0 for the whole transfer.
- IDLE: LED_WREADY=1, BUSY=0, LED_CLOCK=0, LED_LATCH=0.
  - Accept: LED_WVALID & LED_WREADY on an edge captures LED_WDATA into the held word and starts a transfer.
  - Refresh: the refresh counter increments each IDLE cycle. When it reaches REFRESH_CYCLES-1, re-send the held word.
  - The refresh counter clears on any transfer start.
  - Simultaneous accept and refresh: accept wins, and only one transfer occurs.
- SHIFT_LO: LED_DATA = held[bit], LED_CLOCK=0, for H cycles.
- SHIFT_HI: LED_CLOCK=1, LED_DATA unchanged, for H cycles.
  - Then decrement bit and go to SHIFT_LO.
  - After bit 0, go to LATCH.
- LATCH: LED_CLOCK=0, LED_LATCH=1 for H cycles, then go to IDLE.
- While not in IDLE, LED_WREADY=0 and BUSY=1. LED_WVALID is ignored; no queueing. The master holds the word until it is accepted.
- PWM: an 8-bit counter runs 0..254 and wraps to 0. It runs in all states except reset.
  - LED_OE_N = !(pwm_cnt < BRIGHTNESS), registered.
  - BRIGHTNESS=0 gives constant 1; 255 gives constant 0.
- Reset mid-transfer: outputs take reset values on the next edge. LATCH is never pulsed, so the chain's displayed state is unchanged until the CLEAR transfer completes.

## Timing
- All outputs are registered.
- Accept on edge T:
  - LED_WREADY=0 from cycle T+1.
  - The first SHIFT_LO begins at T+1, presenting bit NUM_LEDS-1.
- Transfer length is (2*NUM_LEDS+1)*H cycles. LED_WREADY returns to 1 at T+(2*NUM_LEDS+1)*H+1.
- LED_DATA is stable H cycles before and H cycles after each rising LED_CLOCK edge.
- The LED_LATCH rising edge comes H cycles after the last LED_CLOCK rising edge.
- Refresh period: a transfer starts REFRESH_CYCLES idle cycles after the previous return to IDLE.
- PWM period is 255 cycles.

## Test plan
- Reset release, NUM_LEDS=8, H=2:
  - 8 LED_CLOCK pulses with LED_DATA=0, then a 2-cycle LED_LATCH pulse.
  - LED_WREADY rises 35 cycles after release; LED_OE_N=1 throughout reset.
- Write 0xA5 in IDLE:
  - LED_DATA sampled at the LED_CLOCK rises reads 1,0,1,0,0,1,0,1.
  - A single LATCH follows; LED_WREADY low for exactly 34 cycles.
- LED_WVALID held high with 0x3C during a transfer:
  - Not accepted until LED_WREADY returns.
  - 0x3C is then shifted exactly once.
- REFRESH_CYCLES=50, no writes:
  - The held word is re-sent every 50 idle cycles.
  - A write arriving on the refresh-due cycle produces one transfer, carrying the new data.
- Assert reset during bit 3 of a transfer:
  - All outputs go to reset values next edge; no LATCH pulse is seen.
  - The all-zero CLEAR transfer runs after release.
- BRIGHTNESS sweep 0, 1, 128, 255:
  - LED_OE_N low for 0, 1, 128 and 255 cycles respectively, out of each 255-cycle period.
